isa_ret: RTL and testbench



---
 rtl/isa_pkg.sv | 23 ++
 rtl/isa_ram_rd_txn.sv | 48 ++++
 rtl/isa_ret.sv | 105 ++++++++++
 tb/tb_isa_ret.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Definitions shared by the isa_* instruction executors.
package isa_pkg;
  localparam int         ISA_ADDR_W = 64;
  localparam int         ISA_WORD_W = 32;
  localparam logic [3:0] ISA_SP_REG = 4'd14;

  // RAM handshake phase, common to every executor that touches RAM.
  typedef enum logic {
    PH_BEGIN = 1'b0,
    PH_END   = 1'b1
  } ram_ph_e;

  typedef enum logic [2:0] {
    S_READ_SP,
    S_LATCH_SP,
    S_HI_BEGIN,
    S_HI_END,
    S_LO_BEGIN,
    S_LO_END,
    S_WRITE_SP,
    S_DONE
  } ret_st_e;
endpackage

// File: rtl/isa_ram_rd_txn.sv
// One RAM read: wait for the bus to be idle, then hold the request until done.
module isa_ram_rd_txn
  import isa_pkg::*;
#(
  parameter int ADDR_W = ISA_ADDR_W,
  parameter int WORD_W = ISA_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ram_txe,
  input  logic [WORD_W-1:0] ram_rd,
  output logic              ram_txs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] data,
  output logic              done
);
  ram_ph_e ph;

  // Read data is only meaningful in the cycle done is high.
  assign done = (ph == PH_END) && ram_txe;
  assign data = ram_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph       <= PH_BEGIN;
      ram_txs  <= 1'b0;
      ram_addr <= '0;
    end else if (!enabled) begin
      ph      <= PH_BEGIN;
      ram_txs <= 1'b0;
    end else begin
      case (ph)
        PH_BEGIN: if (start && !ram_txe) begin
          ram_txs  <= 1'b1;
          ram_addr <= addr;
          ph       <= PH_END;
        end
        PH_END: if (ram_txe) begin
          ram_txs <= 1'b0;
          ph      <= PH_BEGIN;
        end
      endcase
    end
  end
endmodule

// File: rtl/isa_ret.sv
// RET executor: pops the 64-bit return address (hi word at SP+1, lo at SP+2) into IP, SP += 2.
module isa_ret
  import isa_pkg::*;
#(
  parameter logic [3:0] SP_REG = ISA_SP_REG,
  parameter int         ADDR_W = ISA_ADDR_W,
  parameter int         WORD_W = ISA_WORD_W   // ADDR_W must be 2*WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enabled,
  input  logic              ram_txe,
  input  logic [WORD_W-1:0] ram_rd,
  input  logic [ADDR_W-1:0] reg_out,
  output logic              ip_set,
  output logic [ADDR_W-1:0] ip_wd,
  output logic              ram_txs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        reg_id,
  output logic [ADDR_W-1:0] reg_wd,
  output logic              reg_re,
  output logic              reg_we,
  output logic              finished
);
  ret_st_e           state;
  logic [ADDR_W-1:0] sp_q;
  logic [WORD_W-1:0] hi_q;
  logic [WORD_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_start;
  logic              rd_done;

  assign ram_we   = 1'b0;
  assign reg_wd   = sp_q + ADDR_W'(2);
  assign rd_start = (state == S_HI_BEGIN) || (state == S_LO_BEGIN);
  assign rd_addr  = sp_q + ((state == S_HI_BEGIN) ? ADDR_W'(1) : ADDR_W'(2));

  isa_ram_rd_txn #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_rd (
    .clk      (clk),
    .rst      (rst),
    .enabled  (enabled),
    .start    (rd_start),
    .addr     (rd_addr),
    .ram_txe  (ram_txe),
    .ram_rd   (ram_rd),
    .ram_txs  (ram_txs),
    .ram_addr (ram_addr),
    .data     (rd_data),
    .done     (rd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_READ_SP;
      sp_q     <= '0;
      hi_q     <= '0;
      ip_wd    <= '0;
      reg_id   <= '0;
      ip_set   <= 1'b0;
      reg_re   <= 1'b0;
      reg_we   <= 1'b0;
      finished <= 1'b0;
    end else if (!enabled) begin
      // Abort: strobes drop, data outputs keep their last value.
      state    <= S_READ_SP;
      ip_set   <= 1'b0;
      reg_re   <= 1'b0;
      reg_we   <= 1'b0;
      finished <= 1'b0;
    end else begin
      ip_set <= 1'b0;
      reg_re <= 1'b0;
      reg_we <= 1'b0;
      case (state)
        S_READ_SP: begin
          reg_id <= SP_REG;
          reg_re <= 1'b1;
          state  <= S_LATCH_SP;
        end
        S_LATCH_SP: begin
          sp_q  <= reg_out;
          state <= S_HI_BEGIN;
        end
        S_HI_BEGIN: if (!ram_txe) state <= S_HI_END;
        S_HI_END: if (rd_done) begin
          hi_q  <= rd_data;
          state <= S_LO_BEGIN;
        end
        S_LO_BEGIN: if (!ram_txe) state <= S_LO_END;
        S_LO_END: if (rd_done) begin
          ip_wd  <= {hi_q, rd_data};
          ip_set <= 1'b1;
          state  <= S_WRITE_SP;
        end
        S_WRITE_SP: begin
          reg_id <= SP_REG;
          reg_we <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: finished <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_isa_ret.sv
// Scoreboard bench for isa_ret: RAM/register-file models, queued expectations, negedge monitor.
module tb_isa_ret;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enabled = 1'b0;
  logic        ram_txe = 1'b0;
  logic [31:0] ram_rd = '0;
  logic [63:0] reg_out = '0;
  logic        ip_set, ram_txs, ram_we, reg_re, reg_we, finished;
  logic [63:0] ip_wd, ram_addr, reg_wd;
  logic [3:0]  reg_id;

  always #5 clk = ~clk;

  isa_ret dut (
    .clk      (clk),
    .rst      (rst),
    .enabled  (enabled),
    .ram_txe  (ram_txe),
    .ram_rd   (ram_rd),
    .reg_out  (reg_out),
    .ip_set   (ip_set),
    .ip_wd    (ip_wd),
    .ram_txs  (ram_txs),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .reg_id   (reg_id),
    .reg_wd   (reg_wd),
    .reg_re   (reg_re),
    .reg_we   (reg_we),
    .finished (finished)
  );

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0, wait_st = 0, age = 0;
  int n_re = 0, n_ip = 0, n_we = 0;
  logic [31:0] mem [logic [63:0]];
  logic [63:0] regs [16];
  logic [63:0] ip_reg = '0;
  logic [63:0] exp_ip[$], exp_sp[$], exp_addr[$];
  int          exp_lat[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event with no expectation queued (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [31:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_A5A5;
  endfunction

  // RAM answers wait_st cycles after the request appears; register file reads combinationally.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (ram_txs) begin
      ram_txe = (age >= wait_st);
      age++;
    end else begin
      ram_txe = 1'b0;
      age = 0;
    end
    ram_rd  = ram_txe ? mem_rd(ram_addr) : 32'h0;
    reg_out = regs[reg_id];
  end

  always @(negedge clk) begin
    if (reg_we) regs[reg_id] = reg_wd;
    if (ip_set) ip_reg = ip_wd;
  end

  logic        prev_txs = 1'b0, prev_fin = 1'b0;
  logic [63:0] hold_addr = '0;
  always @(negedge clk) begin
    if (reg_re) n_re++;
    if (ip_set) begin
      n_ip++;
      if (exp_ip.size() == 0) flag("ip_set");
      else chk("ip_wd", ip_wd, exp_ip.pop_front());
    end
    if (reg_we) begin
      n_we++;
      if (exp_sp.size() == 0) flag("reg_we");
      else begin
        chk("reg_wd", reg_wd, exp_sp.pop_front());
        chk("reg_id_we", 64'(reg_id), 64'd14);
      end
    end
    if (ram_txs && !prev_txs) begin
      if (exp_addr.size() == 0) flag("ram_txs");
      else chk("ram_addr", ram_addr, exp_addr.pop_front());
      chk("ram_we", 64'(ram_we), 64'd0);
      hold_addr = ram_addr;
    end else if (ram_txs) begin
      chk("ram_addr_hold", ram_addr, hold_addr);
    end
    if (finished && !prev_fin) begin
      if (exp_lat.size() == 0) flag("finished");
      else chk("latency", 64'(cyc - start_cyc + 1), 64'(exp_lat.pop_front()));
      chk("reg_re_pulses", 64'(n_re), 64'd1);
      chk("ip_set_pulses", 64'(n_ip), 64'd1);
      chk("reg_we_pulses", 64'(n_we), 64'd1);
    end
    prev_txs = ram_txs;
    prev_fin = finished;
  end

  // Reference: hi word at SP+1, lo word at SP+2, SP advances by 2, all modulo 2^64.
  task automatic push_ret(input logic [63:0] sp, input int w, input int n_acc, input bit full);
    exp_addr.push_back(sp + 64'd1);
    if (n_acc > 1) exp_addr.push_back(sp + 64'd2);
    if (full) begin
      exp_ip.push_back({mem_rd(sp + 64'd1), mem_rd(sp + 64'd2)});
      exp_sp.push_back(sp + 64'd2);
      exp_lat.push_back(9 + 2 * w);
    end
  endtask

  task automatic begin_ret(input int w);
    wait_st = w;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    n_re = 0;
    n_ip = 0;
    n_we = 0;
    enabled = 1'b1;
  endtask

  task automatic end_ret();
    int k = 0;
    while (finished !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (finished !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL finish_timeout: finished still %b after %0d cycles", finished, k);
    end
    @(posedge clk);
    #1 enabled = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("finished_clr", 64'(finished), 64'd0);
  endtask

  task automatic run_ret(input logic [63:0] sp, input int w);
    regs[14] = sp;
    push_ret(sp, w, 2, 1'b1);
    begin_ret(w);
    end_ret();
  endtask

  task automatic wait_rises(input int n);
    int   seen = 0;
    int   k = 0;
    logic p = ram_txs;
    while (seen < n && k < 100) begin
      @(negedge clk);
      if (ram_txs && !p) seen++;
      p = ram_txs;
      k++;
    end
    if (seen < n) begin
      tests++;
      fails++;
      $display("FAIL txs_timeout: saw %0d of %0d requests", seen, n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ip_set"},   64'(ip_set),   64'd0);
    chk({tag, "_ip_wd"},    ip_wd,         64'd0);
    chk({tag, "_ram_txs"},  64'(ram_txs),  64'd0);
    chk({tag, "_ram_we"},   64'(ram_we),   64'd0);
    chk({tag, "_ram_addr"}, ram_addr,      64'd0);
    chk({tag, "_reg_id"},   64'(reg_id),   64'd0);
    chk({tag, "_reg_re"},   64'(reg_re),   64'd0);
    chk({tag, "_reg_we"},   64'(reg_we),   64'd0);
    chk({tag, "_finished"}, 64'(finished), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sp;
    int          w;
    for (int i = 0; i < 16; i++) regs[i] = 64'h1111_0000_0000_0000 + 64'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic pop.
    mem[64'h101] = 32'hDEAD_BEEF;
    mem[64'h102] = 32'h0000_1234;
    run_ret(64'h100, 0);
    chk("basic_ip", ip_reg, 64'hDEAD_BEEF_0000_1234);
    chk("basic_sp", regs[14], 64'h102);

    // SP wraps through zero.
    run_ret(64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("wrap_sp", regs[14], 64'h1);

    // Three wait states per access.
    ip_reg = '0;
    run_ret(64'h100, 3);
    chk("wait_ip", ip_reg, 64'hDEAD_BEEF_0000_1234);

    // Abort during the low-word read, then restart.
    mem[64'h301] = 32'hCAFE_0001;
    mem[64'h302] = 32'hF00D_0002;
    regs[14] = 64'h300;
    ip_reg = 64'h5555;
    push_ret(64'h300, 3, 2, 1'b0);
    begin_ret(3);
    wait_rises(2);
    @(posedge clk);
    #1 enabled = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_txs", 64'(ram_txs), 64'd0);
    chk("abort_ip", ip_reg, 64'h5555);
    chk("abort_sp", regs[14], 64'h300);
    run_ret(64'h300, 3);
    chk("restart_ip", ip_reg, 64'hCAFE_0001_F00D_0002);

    // Reset while the high-word read is outstanding.
    regs[14] = 64'h100;
    push_ret(64'h100, 3, 1, 1'b0);
    begin_ret(3);
    wait_rises(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    push_ret(64'h100, 3, 2, 1'b1);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    n_re = 0;
    n_ip = 0;
    n_we = 0;
    rst = 1'b0;
    end_ret();
    chk("midrst_ip", ip_reg, 64'hDEAD_BEEF_0000_1234);

    // CALL (modelled here) then RET restores IP and SP.
    mem[64'h200] = 32'h0000_0010;
    mem[64'h1FF] = 32'h0000_0042;
    ip_reg = '0;
    run_ret(64'h1FE, 0);
    chk("rt_ip", ip_reg, 64'h0000_0042_0000_0010);
    chk("rt_sp", regs[14], 64'h200);

    for (int i = 0; i < 20; i++) begin
      sp = {$urandom, $urandom};
      if (i % 5 == 0) sp = 64'hFFFF_FFFF_FFFF_FFFF - 64'(i % 3);
      w = $urandom_range(0, 3);
      mem[sp + 64'd1] = $urandom;
      mem[sp + 64'd2] = $urandom;
      run_ret(sp, w);
    end

    chk("queues_empty", 64'(exp_ip.size() + exp_sp.size() + exp_addr.size() + exp_lat.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
